// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART definitions.
// Frame width, FSM states and baud divisor helper.
package uart_rx_pkg;

  localparam int FRAME_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int div_calc(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO.
// Full push with simultaneous pop is accepted.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= rp + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with FWFT byte FIFO.
// RXD is synchronised before the frame FSM sees it.
import uart_rx_pkg::*;

module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rxd,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               overrun
);

  localparam int DIV = div_calc(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  rx_state_t          state;
  logic               s1;
  logic               rxs;
  logic               rxs_d;
  logic [CW-1:0]      cnt;
  logic [2:0]         bitn;
  logic [FRAME_W-1:0] sh;
  logic               push;
  logic               full;
  logic               empty;
  logic               pop;

  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= rxd;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF) begin
            cnt  <= '0;
            bitn <= '0;
            // a start bit gone high by mid-bit is a glitch
            state <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            sh   <= {rxs, sh[FRAME_W-1:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rxs) begin
              push  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
    end
  end

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (sh),
    .pop   (pop),
    .dout  (rx_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// Bytes are queued when sent and checked when popped.
module tb_uart_rx;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcnt = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_HZ     (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid) vcnt++;
    if (rst_n && rx_valid && rx_ready) begin
      if (q.size() == 0) begin
        check("spurious_pop", {24'h0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    if (stop && q.size() < DEPTH) q.push_back(d);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(DIV);
    end
    rxd = stop;
    tick(DIV);
    rxd = 1'b1;
    tick(DIV);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) tick(1);
    tick(2);
    check("drain", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int f0, o0, v0;
    rst_n = 1'b0;
    tick(3);
    check("rst_valid", {31'h0, rx_valid}, 0);
    check("rst_data", {24'h0, rx_data}, 0);
    check("rst_ferr", {31'h0, frame_err}, 0);
    check("rst_ovr", {31'h0, overrun}, 0);
    rst_n = 1'b1;

    f0 = fe_cnt; o0 = ov_cnt; v0 = vcnt;
    tick(200);
    check("idle_ferr", fe_cnt - f0, 0);
    check("idle_ovr", ov_cnt - o0, 0);
    check("idle_valid", vcnt - v0, 0);
    check("idle_data", {24'h0, rx_data}, 0);

    rx_ready = 1'b1;
    v0 = vcnt;
    send(8'hA5, 1'b1);
    drain();
    tick(20);
    check("a5_valid_cycles", vcnt - v0, 1);

    f0 = fe_cnt; v0 = vcnt;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(40);
    check("glitch_ferr", fe_cnt - f0, 0);
    check("glitch_valid", vcnt - v0, 0);

    f0 = fe_cnt;
    send(8'h3C, 1'b0);
    tick(20);
    check("ferr_pulses", fe_cnt - f0, 1);
    check("ferr_empty", {31'h0, rx_valid}, 0);
    send(8'h81, 1'b1);
    drain();

    rx_ready = 1'b0;
    o0 = ov_cnt;
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
    tick(10);
    check("ovr_pulses", ov_cnt - o0, 1);
    check("ovr_valid", {31'h0, rx_valid}, 1);
    check("ovr_head", {24'h0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    drain();
    check("ovr_drained", {31'h0, rx_valid}, 0);

    rxd = 1'b0;
    tick(DIV);
    rxd = 1'b1;
    tick(3 * DIV);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, rx_valid}, 0);
    check("mid_rst_data", {24'h0, rx_data}, 0);
    tick(3);
    check("mid_rst_ferr", {31'h0, frame_err}, 0);
    check("mid_rst_ovr", {31'h0, overrun}, 0);
    rst_n = 1'b1;
    f0 = fe_cnt;
    tick(30);
    send(8'h5A, 1'b1);
    drain();
    check("post_rst_ferr", fe_cnt - f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
